// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller behind the UART receiver: hunts SYNC, assembles
// SYNC/CMD/ADDR/DATA/CHK, and issues one-cycle register write/read strobes or an error pulse.
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] CMD_WR    = 8'h01,
  parameter logic [7:0] CMD_RD    = 8'h02,
  parameter int         TIMEOUT   = 2048
) (
  input  logic       baud_clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_busy,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       wr_en,
  output logic       rd_en,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_CMD  = 3'd1,
    GET_ADDR = 3'd2,
    GET_DATA = 3'd3,
    GET_CHK  = 3'd4
  } state_t;

  state_t           state, state_n;
  logic             rx_busy_q;
  logic             byte_ev;
  logic [7:0]       cmd_q, addr_q, data_q;
  logic [7:0]       cmd_n, addr_n, data_n;
  logic [7:0]       reg_addr_n, reg_wdata_n;
  logic [7:0]       sum;
  logic             wr_n, rd_n, err_n;
  logic [1:0]       err_code_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  // A completed byte is the falling edge of the receiver busy flag.
  assign byte_ev = rx_busy_q && !rx_busy;
  assign sum     = cmd_q + addr_q + data_q;
  assign busy    = (state != IDLE);

  always_ff @(posedge baud_clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rx_busy_q <= 1'b0;
      cmd_q     <= 8'h00;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      cnt       <= '0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state     <= state_n;
      rx_busy_q <= rx_busy;
      cmd_q     <= cmd_n;
      addr_q    <= addr_n;
      data_q    <= data_n;
      cnt       <= cnt_n;
      reg_addr  <= reg_addr_n;
      reg_wdata <= reg_wdata_n;
      wr_en     <= wr_n;
      rd_en     <= rd_n;
      err       <= err_n;
      err_code  <= err_code_n;
    end
  end

  always_comb begin
    state_n     = state;
    cmd_n       = cmd_q;
    addr_n      = addr_q;
    data_n      = data_q;
    reg_addr_n  = reg_addr;
    reg_wdata_n = reg_wdata;
    wr_n        = 1'b0;
    rd_n        = 1'b0;
    err_n       = 1'b0;
    err_code_n  = err_code;
    cnt_n       = cnt;

    case (state)
      IDLE: begin
        if (byte_ev && rx_data == SYNC_BYTE) state_n = GET_CMD;
      end
      GET_CMD: begin
        if (byte_ev) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            cmd_n   = rx_data;
            state_n = GET_ADDR;
          end else begin
            state_n    = IDLE;
            err_n      = 1'b1;
            err_code_n = 2'd1;
          end
        end
      end
      GET_ADDR: begin
        if (byte_ev) begin
          addr_n  = rx_data;
          state_n = GET_DATA;
        end
      end
      GET_DATA: begin
        if (byte_ev) begin
          data_n  = rx_data;
          state_n = GET_CHK;
        end
      end
      GET_CHK: begin
        if (byte_ev) begin
          state_n = IDLE;
          if (sum == rx_data) begin
            reg_addr_n  = addr_q;
            reg_wdata_n = data_q;
            wr_n        = (cmd_q == CMD_WR);
            rd_n        = (cmd_q == CMD_RD);
          end else begin
            err_n      = 1'b1;
            err_code_n = 2'd2;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Timeout sits in the else branch so a coincident byte event always wins.
    if (state == IDLE || byte_ev || rx_busy) begin
      cnt_n = '0;
    end else if (cnt == CNT_LAST) begin
      cnt_n      = '0;
      state_n    = IDLE;
      err_n      = 1'b1;
      err_code_n = 2'd3;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frames, garbage, bad command, checksum,
// timeout, rx_busy hold and mid-frame reset, with hand-computed expectations.
module tb_uart_cmd_ctrl;

  localparam int TIMEOUT = 2048;

  logic       baud_clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_busy;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       wr_en;
  logic       rd_en;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, overlap_cnt = 0;
  int wr_s, rd_s, err_s;
  int n;

  uart_cmd_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .baud_clk  (baud_clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_busy   (rx_busy),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .err       (err),
    .err_code  (err_code),
    .busy      (busy)
  );

  // clock / reset
  initial begin
    baud_clk = 1'b0;
    forever #5 baud_clk = ~baud_clk;
  end

  // pulse monitor, sampled on the falling edge
  always @(negedge baud_clk) begin
    if (wr_en) wr_cnt++;
    if (rd_en) rd_cnt++;
    if (err)   err_cnt++;
    if ((int'(wr_en) + int'(rd_en) + int'(err)) > 1) overlap_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: called on a falling edge, returns on the falling edge after the byte is registered
  task automatic send_byte(input logic [7:0] b);
    rx_busy = 1'b1;
    repeat (2) @(negedge baud_clk);
    rx_data = b;
    rx_busy = 1'b0;
    @(negedge baud_clk);
  endtask

  task automatic snap();
    wr_s = wr_cnt; rd_s = rd_cnt; err_s = err_cnt;
  endtask

  initial begin
    reset   = 1'b0;
    rx_busy = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge baud_clk);

    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_rd_en", rd_en, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_err_code", err_code, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_reg_addr", reg_addr, 0);
    check_eq("rst_reg_wdata", reg_wdata, 0);
    reset = 1'b1;
    repeat (2) @(negedge baud_clk);

    // write frame A5,01,10,3C,4D
    snap();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C);
    check_eq("wr_busy_mid", busy, 1);
    send_byte(8'h4D);
    check_eq("wr_strobe", wr_en, 1);
    check_eq("wr_rd_en", rd_en, 0);
    check_eq("wr_addr", reg_addr, 8'h10);
    check_eq("wr_wdata", reg_wdata, 8'h3C);
    check_eq("wr_busy_end", busy, 0);
    @(negedge baud_clk);
    check_eq("wr_strobe_drop", wr_en, 0);
    check_eq("wr_pulses", wr_cnt - wr_s, 1);
    check_eq("wr_no_err", err_cnt - err_s, 0);

    // read frame A5,02,22,00,24
    snap();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h22); send_byte(8'h00); send_byte(8'h24);
    check_eq("rd_strobe", rd_en, 1);
    check_eq("rd_addr", reg_addr, 8'h22);
    check_eq("rd_wdata", reg_wdata, 8'h00);
    @(negedge baud_clk);
    check_eq("rd_pulses", rd_cnt - rd_s, 1);
    check_eq("rd_no_wr", wr_cnt - wr_s, 0);

    // garbage then write frame A5,01,05,AA,B0
    snap();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    check_eq("garbage_busy", busy, 0);
    check_eq("garbage_no_err", err_cnt - err_s, 0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05); send_byte(8'hAA); send_byte(8'hB0);
    check_eq("g_wr_addr", reg_addr, 8'h05);
    check_eq("g_wr_wdata", reg_wdata, 8'hAA);
    @(negedge baud_clk);
    check_eq("g_wr_pulses", wr_cnt - wr_s, 1);

    // bad command, then a valid read frame A5,02,33,01,36
    snap();
    send_byte(8'hA5); send_byte(8'h07);
    check_eq("badcmd_err", err, 1);
    check_eq("badcmd_code", err_code, 1);
    check_eq("badcmd_busy", busy, 0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h33); send_byte(8'h01); send_byte(8'h36);
    check_eq("after_bad_rd", rd_en, 1);
    check_eq("after_bad_addr", reg_addr, 8'h33);
    check_eq("after_bad_wdata", reg_wdata, 8'h01);
    check_eq("code_hold", err_code, 1);
    @(negedge baud_clk);
    check_eq("badcmd_err_pulses", err_cnt - err_s, 1);

    // SYNC in CMD slot counts as bad command
    send_byte(8'hA5); send_byte(8'hA5);
    check_eq("sync_as_cmd_err", err, 1);
    check_eq("sync_as_cmd_busy", busy, 0);

    // checksum error A5,01,10,3C,4E
    snap();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C); send_byte(8'h4E);
    check_eq("chk_err", err, 1);
    check_eq("chk_code", err_code, 2);
    check_eq("chk_addr_hold", reg_addr, 8'h33);
    check_eq("chk_wdata_hold", reg_wdata, 8'h01);
    @(negedge baud_clk);
    check_eq("chk_no_wr", wr_cnt - wr_s, 0);

    // timeout after A5,01: counter reaches TIMEOUT-1 after TIMEOUT-1 edges, err on the next
    snap();
    send_byte(8'hA5); send_byte(8'h01);
    n = 0;
    while (!err && n < TIMEOUT + 10) begin
      @(negedge baud_clk);
      n++;
    end
    check_eq("to_cycles", n, TIMEOUT);
    check_eq("to_err", err, 1);
    check_eq("to_code", err_code, 3);
    check_eq("to_busy", busy, 0);
    @(negedge baud_clk);
    check_eq("to_err_pulses", err_cnt - err_s, 1);

    // rx_busy held high: no timeout, state holds
    snap();
    send_byte(8'hA5);
    rx_busy = 1'b1;
    repeat (TIMEOUT + 500) @(negedge baud_clk);
    check_eq("hold_busy", busy, 1);
    check_eq("hold_no_err", err_cnt - err_s, 0);
    rx_data = 8'h01;
    rx_busy = 1'b0;
    @(negedge baud_clk);
    send_byte(8'h10);
    check_eq("pre_rst_busy", busy, 1);

    // reset mid-frame after A5,01,10
    reset = 1'b0;
    #1;
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_addr", reg_addr, 0);
    check_eq("mrst_wdata", reg_wdata, 0);
    check_eq("mrst_code", err_code, 0);
    repeat (2) @(negedge baud_clk);
    reset = 1'b1;
    @(negedge baud_clk);
    send_byte(8'h3C); send_byte(8'h4D);
    @(negedge baud_clk);
    check_eq("mrst_no_wr", wr_cnt - wr_s, 0);
    check_eq("mrst_no_rd", rd_cnt - rd_s, 0);
    check_eq("mrst_no_err", err_cnt - err_s, 0);
    check_eq("mrst_idle", busy, 0);

    check_eq("no_overlap", overlap_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command-frame controller that sits directly behind the UART receiver and runs on the same 16x oversampled baud clock.
- Consumes received bytes, hunts for a sync byte and assembles a 5-byte command frame: SYNC, CMD, ADDR, DATA, CHK.
- Validates each frame and issues one-cycle register write or read strobes to the downstream register bank.
- Aborts partial frames on bad command, checksum mismatch or inter-byte timeout, and reports the cause on an error pulse/code.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
CMD_WR, 8'h01, command code for register write
CMD_RD, 8'h02, command code for register read
TIMEOUT, 2048, baud_clk cycles allowed between bytes inside a frame (counted only while rx_busy low); must be >= 2

Ports:
baud_clk  input  1  16x oversampled baud clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
rx_data  input  8  received byte from UART receiver; valid when a byte event occurs
rx_busy  input  1  receiver busy flag; high during reception, a 1->0 transition marks a completed byte
reg_addr  output  8  register address of last accepted frame
reg_wdata  output  8  write data of last accepted frame
wr_en  output  1  one-cycle write strobe
rd_en  output  1  one-cycle read strobe
err  output  1  one-cycle error pulse
err_code  output  2  cause of last error: 1 bad CMD, 2 checksum, 3 timeout; holds until next error
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; internal byte registers, timeout counter and rx_busy delay flop cleared.
- Byte event: rx_busy_q==1 && rx_busy==0, where rx_busy_q is rx_busy registered once. rx_data is sampled in the same cycle. At most one byte event per cycle.
- States: IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK.
- IDLE: byte == SYNC_BYTE -> GET_CMD. Any other byte is discarded silently (no err).
- GET_CMD: byte == CMD_WR or CMD_RD -> store, go to GET_ADDR. Otherwise -> IDLE with err=1, err_code=1. A SYNC_BYTE here is treated as a bad CMD.
- GET_ADDR: store byte -> GET_DATA.
- GET_DATA: store byte -> GET_CHK. The DATA byte is required for reads too; it is ignored except in the checksum.
- GET_CHK: compute (CMD+ADDR+DATA) mod 256.
  - Equal to byte: on the next edge reg_addr/reg_wdata load and exactly one of wr_en/rd_en pulses for one cycle; state -> IDLE on that same edge.
  - Not equal: -> IDLE, err=1, err_code=2, reg_addr/reg_wdata unchanged.
- Latency: strobe asserted on the first rising edge after the CHK byte-event cycle (registered output).
- reg_addr/reg_wdata: change only on an accepted frame; hold otherwise. On an accepted read, reg_wdata loads the DATA byte.
- Timeout counter:
  - Cleared in IDLE, on every byte event, and while rx_busy high.
  - Otherwise increments each cycle in non-IDLE states.
  - On reaching TIMEOUT-1: -> IDLE, err=1, err_code=3, counter cleared.
  - If a byte event and timeout coincide, the byte event wins; no error.
- Pulse rules: err, wr_en and rd_en are one-cycle pulses, never asserted together. err_code updates only when err pulses.
- Back-to-back frames: a SYNC_BYTE arriving in the cycle after the strobe is accepted normally.
- Reset mid-frame: returns to IDLE immediately, partial frame discarded, no strobe or err generated.
- rx_busy held high indefinitely: no timeout and no byte events; state holds.

Test Plan:
- Write frame A5,01,10,3C,4D -> single wr_en pulse 1 cycle after last byte event, reg_addr=10, reg_wdata=3C, err never asserted.
- Read frame A5,02,22,00,24 -> single rd_en pulse, reg_addr=22, reg_wdata=00, wr_en stays 0.
- Garbage 00,FF,13 then write frame A5,01,05,AA,B0 -> no err for garbage, wr_en once with reg_addr=05, reg_wdata=AA.
- Bad CMD A5,07 -> err pulse, err_code=1, busy=0; a following valid frame is accepted normally.
- Checksum error A5,01,10,3C,4E -> err, err_code=2, no wr_en, reg_addr/reg_wdata keep previous values.
- Timeout: A5,01 then rx_busy low for TIMEOUT cycles -> err, err_code=3, busy drops. Separately, assert reset mid-frame after A5,01,10 -> all outputs 0, state IDLE, no pulses.
